// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter
// ------------------
// Shares the single write port of the `ram` SDRAM controller between two
// write requesters (0 = terminal_stream, 1 = scroll/fill engine). One
// requester is granted at a time. The grant is held for the whole
// transaction, bursts included, until `ram` pulses wr_done. That pulse is
// routed back only to the owner.
//
// Arbitration is round-robin by default. Define
// RAM_WRITE_ARBITER_FIXED_PRIORITY_EN to make requester 0 always win
// simultaneous requests. The FSM, the latency and the outputs are otherwise
// identical in both builds.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   wr_request_n                level request from requester n, held until
//                               its wr_done_n
//   wr_address_n / wr_data_n / wr_mask_n / wr_burst_length_n
//                               transaction fields from requester n
//   wr_done_n                   completion pulse back to requester n
//   granted_n                   requester n currently owns the port
//   wr_request, wr_address, wr_data, wr_mask, wr_burst_length
//                               write port towards `ram`
//   wr_done                     one-cycle completion pulse from `ram`
module ram_write_arbiter #(
  parameter int ADDRESS_WIDTH = 23,
  parameter int DATA_WIDTH    = 32,
  parameter int MASK_WIDTH    = 4,
  parameter int BURST_WIDTH   = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_request_0,
  input  logic                     wr_request_1,
  input  logic [ADDRESS_WIDTH-1:0] wr_address_0,
  input  logic [ADDRESS_WIDTH-1:0] wr_address_1,
  input  logic [DATA_WIDTH-1:0]    wr_data_0,
  input  logic [DATA_WIDTH-1:0]    wr_data_1,
  input  logic [MASK_WIDTH-1:0]    wr_mask_0,
  input  logic [MASK_WIDTH-1:0]    wr_mask_1,
  input  logic [BURST_WIDTH-1:0]   wr_burst_length_0,
  input  logic [BURST_WIDTH-1:0]   wr_burst_length_1,
  output logic                     wr_done_0,
  output logic                     wr_done_1,
  output logic                     granted_0,
  output logic                     granted_1,
  output logic                     wr_request,
  output logic [ADDRESS_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [MASK_WIDTH-1:0]    wr_mask,
  output logic [BURST_WIDTH-1:0]   wr_burst_length,
  input  logic                     wr_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   lastGrant_q, lastGrant_d;

  // State registers. lastGrant resets to 1 so that requester 0 wins the
  // first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // Next-state logic. IDLE picks a winner. ACTIVE waits for ram's done
  // pulse, ignoring the owner's request level so that a burst is never
  // abandoned. RELEASE is a single dead cycle that lets the finished
  // requester drop its request before the next arbitration.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      IDLE: begin
        if (wr_request_0 && wr_request_1) begin
`ifdef RAM_WRITE_ARBITER_FIXED_PRIORITY_EN
          grant_d = 1'b0;
`else
          grant_d = ~lastGrant_q;
`endif
          state_d = ACTIVE;
        end else if (wr_request_0) begin
          grant_d = 1'b0;
          state_d = ACTIVE;
        end else if (wr_request_1) begin
          grant_d = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (wr_done) begin
          lastGrant_d = grant_q;
          state_d     = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The data path is a pure combinational mux, so burst beats
  // from the owner reach ram with no added latency. Outside ACTIVE every
  // output is forced to zero, and a stray wr_done is swallowed.
  always_comb begin
    wr_request      = 1'b0;
    granted_0       = 1'b0;
    granted_1       = 1'b0;
    wr_done_0       = 1'b0;
    wr_done_1       = 1'b0;
    wr_address      = '0;
    wr_data         = '0;
    wr_mask         = '0;
    wr_burst_length = '0;
    if (state_q == ACTIVE) begin
      wr_request = 1'b1;
      granted_0  = ~grant_q;
      granted_1  = grant_q;
      wr_done_0  = wr_done & ~grant_q;
      wr_done_1  = wr_done & grant_q;
      if (grant_q) begin
        wr_address      = wr_address_1;
        wr_data         = wr_data_1;
        wr_mask         = wr_mask_1;
        wr_burst_length = wr_burst_length_1;
      end else begin
        wr_address      = wr_address_0;
        wr_data         = wr_data_0;
        wr_mask         = wr_mask_0;
        wr_burst_length = wr_burst_length_0;
      end
    end
  end

endmodule

// File: doc/ram_write_arbiter.md
# ram_write_arbiter

Shares the single write port of the `ram` SDRAM controller between two write requesters. Requester 0 is `terminal_stream`; requester 1 is the planned scroll/fill engine. The block sits between these masters and `ram`'s `wr_*` port. It grants one requester at a time, holds the grant for the whole transaction (including bursts) until `wr_done`, and routes `wr_done` back only to the granted requester. Arbitration is round-robin by default; fixed priority is selectable at compile time.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 23, RAM word address width
- `DATA_WIDTH`, 32, write data width
- `MASK_WIDTH`, 4, byte mask width
- `BURST_WIDTH`, 9, burst length width

Ports:
- `clk` in 1: system clock, 108 MHz
- `reset` in 1: synchronous, active-high reset
- `wr_request_0`, `wr_request_1` in 1: level request from requester n, held until its `wr_done_n`
- `wr_address_0`, `wr_address_1` in `ADDRESS_WIDTH`: start address from requester n
- `wr_data_0`, `wr_data_1` in `DATA_WIDTH`: write data from requester n
- `wr_mask_0`, `wr_mask_1` in `MASK_WIDTH`: byte mask from requester n
- `wr_burst_length_0`, `wr_burst_length_1` in `BURST_WIDTH`: burst length from requester n
- `wr_done_0`, `wr_done_1` out 1: completion pulse to requester n
- `granted_0`, `granted_1` out 1: requester n currently owns the port
- `wr_request` out 1: request to `ram`
- `wr_address` out `ADDRESS_WIDTH`: address to `ram`
- `wr_data` out `DATA_WIDTH`: write data to `ram`
- `wr_mask` out `MASK_WIDTH`: byte mask to `ram`
- `wr_burst_length` out `BURST_WIDTH`: burst length to `ram`
- `wr_done` in 1: one-cycle completion pulse from `ram`

## Operation
- FSM states: IDLE, ACTIVE, RELEASE. Registers: `state`, `grant` (1 bit), `last_grant` (1 bit).
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it and go to ACTIVE.
  - Both requests, round-robin: grant `~last_grant`.
- ACTIVE:
  - `wr_request` = 1.
  - Data-path outputs (`wr_address`, `wr_data`, `wr_mask`, `wr_burst_length`) combinationally mux the granted requester's inputs, so burst beats pass through unregistered.
  - On `wr_done` = 1: `wr_done_<grant>` = `wr_done` combinationally, `last_grant` <= `grant`, next state RELEASE.
- RELEASE: `wr_request` = 0, all grants 0. Lasts one cycle, giving the requester time to drop its request, then returns to IDLE.
- Outside ACTIVE: data-path outputs are driven to 0, and `wr_done_0`/`wr_done_1` are 0 regardless of `wr_done`.
- A `wr_done` that arrives outside ACTIVE is ignored.
- If the granted requester drops `wr_request_n` before done (protocol violation), the grant is still held until `wr_done`. `ram` is never abandoned mid-burst.
- The non-granted requester's request is ignored. It stays pending and is never lost.

## Timing
- Reset values: `state` = IDLE, `grant` = 0, `last_grant` = 1 (requester 0 wins the first tie). All outputs are 0.
- Grant latency: request sampled high at edge N; `granted_n` = 1 and `wr_request` = 1 from N+1.
- Done at cycle D:
  - `wr_done_n` is high in cycle D only.
  - `wr_request` and `granted_n` are low from D+1.
  - RELEASE occupies D+1; IDLE evaluates requests at D+2; the next grant is visible at D+3.
- Back-to-back: `wr_request` to `ram` has at least 2 low cycles between transactions.
- Worst-case wait for a requester with the other requester continuously active: one foreign transaction plus 3 cycles (round-robin).
- Reset mid-transaction: all outputs are 0 on the next cycle. Requesters and `ram` share the same reset.

## Configuration
- `RAM_WRITE_ARBITER_FIXED_PRIORITY_EN`:
  - Defined: requester 0 always wins simultaneous requests in IDLE. `last_grant` is still updated but not used.
  - Undefined: round-robin as described above.
  - Nothing else changes: FSM, latency and outputs are identical in both builds.

## Test plan
- Reset, then `wr_request_0` = 1 with `wr_address_0` = 23'h000100 and `wr_data_0` = 32'hDEADBEEF:
  - One cycle later, `wr_request` = 1 and `wr_address` = 23'h000100.
  - `wr_done` pulse: `wr_done_0` = 1 in the same cycle; `wr_request` = 0 on the next cycle.
- Both requests held high continuously, `ram` answers each request after 5 cycles:
  - Grant order is 0,1,0,1.
  - Each `wr_done_n` goes only to its owner.
  - Exactly 2 idle cycles of `wr_request` between transactions.
- Same stimulus built with `RAM_WRITE_ARBITER_FIXED_PRIORITY_EN`, requester 0 re-requesting immediately after each done: requester 1 is never granted while requester 0 requests.
- Burst of length 9'd8, `wr_data_1` changing every cycle while granted: `wr_data` follows `wr_data_1` cycle-for-cycle with zero added latency.
- Spurious `wr_done` in IDLE: no `wr_done_n`, no state change. Reset asserted in ACTIVE: `wr_request` = 0 and `granted_0` = `granted_1` = 0 on the next cycle.
- Requester 0 drops `wr_request_0` mid-ACTIVE: `wr_request` stays 1 until `wr_done`, then RELEASE/IDLE. A pending `wr_request_1` is granted at D+3.
